fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that replaces the combinational imem port.
- Talks to a pipelined instruction memory through a request/response handshake, buffers fetched words in a small in-order queue, and hands {instruction, pc} to the downstream decode/execute core through a valid/ready interface.
- Accepts redirects (taken branch, jump, trap) from downstream, flushes queued and in-flight fetches, and restarts at the new pc.

Parameters:
- RESET_ADDR, 32'h00000000, first fetch address after reset.
- DEPTH, 4, queue entries; power of two, 2..16; also the maximum number of live in-flight requests.

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- o_mem_req  out  1  fetch request valid.
- o_mem_addr  out  32  fetch address, always 4-byte aligned.
- i_mem_ready  in  1  memory accepts the request this cycle (transfer = o_mem_req & i_mem_ready).
- i_mem_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- i_mem_rdata  in  32  response instruction word.
- o_inst_valid  out  1  queue head valid.
- o_inst  out  32  head instruction word.
- o_inst_pc  out  32  head pc.
- o_inst_fault  out  1  head is a misaligned-fetch fault entry; o_inst is 32'h0 for fault entries.
- i_inst_ready  in  1  downstream consumes head (transfer = o_inst_valid & i_inst_ready).
- i_redirect  in  1  flush and restart.
- i_redirect_pc  in  32  restart address.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - fetch_pc = RESET_ADDR, queue empty, outstanding = 0, drop = 0, state = FETCH.
  - o_mem_req = 0, o_inst_valid = 0, o_inst_fault = 0.
  - Reset mid-operation discards everything; responses to pre-reset requests are not the block's concern (memory is reset together).
- States:
  - FETCH: normal operation.
  - FAULT: fetching stopped after a misaligned redirect; exits only on i_redirect.
- Request issue:
  - o_mem_req = (state == FETCH) & !i_redirect & (count + (outstanding - drop) < DEPTH).
  - o_mem_addr = fetch_pc.
  - On transfer: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
  - o_mem_req and o_mem_addr stay stable until accepted unless i_redirect.
- Response handling:
  - On i_mem_valid, outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise the word is enqueued with pc = resp_pc; resp_pc then += 4.
  - Credit check guarantees no overflow; an enqueue to a full queue is an assertion failure.
- Output:
  - Head registered in queue storage; no combinational path from i_mem_rdata to o_inst.
  - Minimum latency: request accepted cycle t, response cycle t+1, o_inst_valid cycle t+2.
  - Enqueue and dequeue in the same cycle are both allowed at any count, including full.
- Redirect (priority over every other update that cycle):
  - A consumer handshake in the same cycle still counts as transferred.
  - Remaining queue entries are flushed.
  - drop = outstanding after this cycle's response is counted, i.e. outstanding - i_mem_valid.
  - If i_redirect_pc[1:0] == 0: fetch_pc = resp_pc = i_redirect_pc and state = FETCH; the first new request is issued the next cycle.
  - If misaligned: enqueue one entry {inst = 0, pc = i_redirect_pc, fault = 1} into the emptied queue and go to FAULT. No requests are issued until the next redirect; stale drops continue.
- Arithmetic:
  - count is clog2(DEPTH)+1 bits.
  - outstanding and drop are clog2(DEPTH)+1 bits; drop <= outstanding always.
- Boundaries:
  - Queue full with 0 live outstanding: no request.
  - Count 3 with 1 live outstanding (DEPTH = 4): no request.
  - Redirect with queue empty and 0 outstanding: drop = 0.
  - Back-to-back redirects: the second redirect wins, and drop accumulates correctly because it is derived from total outstanding.

Decomposition:
- Shared package: fetch state enum (FETCH, FAULT), INST_NOP constant (32'h00000013), and the fault-entry encoding.
- One sub-module is natural: fetch_queue, a parameterised synchronous FIFO with flush, push, pop, count and the head {inst, pc, fault}.

Test Plan:
- Zero-wait memory (ready = 1, 1-cycle response), i_inst_ready = 1, RESET_ADDR = 0 -> o_inst_pc sequence 0, 4, 8, 12..., one instruction per cycle after cycle 2; words match memory.
- i_inst_ready = 0 for 10 cycles -> exactly 4 entries queued, o_mem_req low once count + live = 4. Release -> pcs 0, 4, 8, 12 in order, no loss or duplication.
- 3-cycle response latency, 2 requests in flight, i_redirect pc = 0x100 -> both stale words dropped; next o_inst_pc = 0x100 with mem[0x100]; no stale pc ever visible.
- Redirect in the same cycle as i_mem_valid and a consumer handshake -> the handshaken instruction is counted once, the response is dropped, drop ends at 0 after the remaining responses arrive.
- i_redirect_pc = 0x202 -> one entry {fault = 1, pc = 0x202, inst = 0}, no o_mem_req until redirect to 0x300, then normal fetch from 0x300.
- i_rst_n pulsed low mid-stream with a full queue -> outputs 0 immediately (async); after release the first request address is RESET_ADDR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [0:0] {
        StFetch,
        StFault
    } fetch_state_e;

    // Instruction presented while the queue head is empty (addi x0, x0, 0).
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    // Instruction word carried by a misaligned-fetch fault entry.
    localparam logic [31:0] FAULT_INST = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    function automatic fetch_entry_t make_word_entry(input logic [31:0] inst,
                                                     input logic [31:0] pc);
        fetch_entry_t e;
        e.inst  = inst;
        e.pc    = pc;
        e.fault = 1'b0;
        return e;
    endfunction

    function automatic fetch_entry_t make_fault_entry(input logic [31:0] pc);
        fetch_entry_t e;
        e.inst  = FAULT_INST;
        e.pc    = pc;
        e.fault = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: synchronous FIFO with flush; a push in the flush cycle
// lands in the freshly emptied queue.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    output logic [CW-1:0] o_count,
    output logic         o_head_valid,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_pop_ok;
    logic [AW-1:0] w_wr_idx;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop_ok = i_pop & (r_count != '0);
    assign w_wr_idx = i_flush ? '0 : r_wr_ptr;

    // Storage array; no reset needed since the head is qualified by count.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_push_entry;
        end
    end

    // Pointer and occupancy update; flush rewinds both pointers to slot 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= AW'(i_push);
            r_count  <= CW'(i_push);
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(w_pop_ok);
        end
    end

    // The issue-side credit check must make an overflowing push impossible.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
                     !(i_push && !i_flush && w_full && !i_pop));

    assign o_count      = r_count;
    assign o_head_valid = (r_count != '0);
    assign o_head       = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues pipelined memory requests under a credit
// limit, queues responses in order and drops responses made stale by redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_fault,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_e  r_state;
    logic          r_active;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    fetch_state_e  w_state_d;
    logic [31:0]   w_fetch_pc_d;
    logic [31:0]   w_resp_pc_d;
    logic [CW-1:0] w_outstanding_d;
    logic [CW-1:0] w_drop_d;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_live;
    logic          w_credit_ok;
    logic          w_req;
    logic          w_req_fire;
    logic          w_drop_hit;
    logic          w_resp_keep;
    logic          w_pop;
    logic          w_flush;
    logic          w_push;
    fetch_entry_t  w_push_entry;
    logic          w_head_valid;
    fetch_entry_t  w_head;

    assign w_live      = r_outstanding - r_drop;
    assign w_credit_ok = (SW'(w_count) + SW'(w_live)) < SW'(DEPTH);
    // Stale plus live requests must also fit the outstanding counter.
    assign w_req       = r_active & (r_state == StFetch) & ~i_redirect & w_credit_ok &
                         (r_outstanding != '1);
    assign w_req_fire  = w_req & i_mem_ready;
    assign w_drop_hit  = i_mem_valid & (r_drop != '0);
    assign w_resp_keep = i_mem_valid & (r_drop == '0);
    assign w_pop       = w_head_valid & i_inst_ready;

    assign o_mem_req   = w_req;
    assign o_mem_addr  = {r_fetch_pc[31:2], 2'b00};

    // Next-state, counter and queue control; a redirect overrides everything.
    always_comb begin
        w_state_d       = r_state;
        w_fetch_pc_d    = r_fetch_pc;
        w_resp_pc_d     = r_resp_pc;
        w_outstanding_d = r_outstanding + CW'(w_req_fire) - CW'(i_mem_valid);
        w_drop_d        = r_drop - CW'(w_drop_hit);
        w_flush         = 1'b0;
        w_push          = w_resp_keep;
        w_push_entry    = make_word_entry(i_mem_rdata, r_resp_pc);

        if (w_req_fire) begin
            w_fetch_pc_d = r_fetch_pc + 32'd4;
        end
        if (w_resp_keep) begin
            w_resp_pc_d = r_resp_pc + 32'd4;
        end

        if (i_redirect) begin
            w_flush      = 1'b1;
            w_drop_d     = r_outstanding - CW'(i_mem_valid);
            w_fetch_pc_d = i_redirect_pc;
            w_resp_pc_d  = i_redirect_pc;
            if (i_redirect_pc[1:0] == 2'b00) begin
                w_state_d = StFetch;
                w_push    = 1'b0;
            end else begin
                w_state_d    = StFault;
                w_push       = 1'b1;
                w_push_entry = make_fault_entry(i_redirect_pc);
            end
        end
    end

    // State and counter registers; r_active holds off issue during reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StFetch;
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_ADDR;
            r_resp_pc     <= RESET_ADDR;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_state       <= w_state_d;
            r_active      <= 1'b1;
            r_fetch_pc    <= w_fetch_pc_d;
            r_resp_pc     <= w_resp_pc_d;
            r_outstanding <= w_outstanding_d;
            r_drop        <= w_drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (w_flush),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head       (w_head)
    );

    assign o_inst_valid = w_head_valid;
    assign o_inst       = w_head_valid ? w_head.inst : INST_NOP;
    assign o_inst_pc    = w_head_valid ? w_head.pc : 32'h0;
    assign o_inst_fault = w_head_valid & w_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a pipelined memory model plus a program-order
// reference stream (expected next pc, fault entries) checked on every consume.
module tb_fetch_unit;

    localparam int unsigned DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_fault;
    logic        i_inst_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    fetch_unit #(
        .RESET_ADDR (RESET_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ready   (i_mem_ready),
        .i_mem_valid   (i_mem_valid),
        .i_mem_rdata   (i_mem_rdata),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .o_inst_fault  (o_inst_fault),
        .i_inst_ready  (i_inst_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory model: accepted addresses with the cycle their response is due.
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Reference stream and bookkeeping.
    int          cyc;
    logic [31:0] exp_pc;
    logic [31:0] fault_pc;
    bit          in_fault;
    bit          exp_fault_next;
    bit          prev_stall;
    logic [31:0] prev_addr;
    int          req_cnt, cons_cnt, fault_seen, gaps;
    int          first_acc, first_valid;
    logic [31:0] first_acc_addr;
    int          lat_min, lat_max, mrdy_pct, irdy_pct;
    bit          arm_redir, arm_hit;
    logic [31:0] arm_pc;

    task automatic model_reset();
        pend_addr.delete();
        pend_due.delete();
        cyc            = 0;
        exp_pc         = RESET_ADDR;
        fault_pc       = 32'h0;
        in_fault       = 1'b0;
        exp_fault_next = 1'b0;
        prev_stall     = 1'b0;
        prev_addr      = 32'h0;
        req_cnt        = 0;
        cons_cnt       = 0;
        fault_seen     = 0;
        gaps           = 0;
        first_acc      = -1;
        first_valid    = -1;
        first_acc_addr = 32'hFFFF_FFFF;
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_mem_valid   = 1'b0;
        i_mem_ready   = 1'b0;
        i_mem_rdata   = 32'h0;
        i_inst_ready  = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        int lat;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            i_mem_valid = 1'b1;
            i_mem_rdata = mem_word(pend_addr[0]);
        end else begin
            i_mem_valid = 1'b0;
            i_mem_rdata = $urandom;
        end
        i_mem_ready   = ($urandom_range(99) < mrdy_pct);
        i_inst_ready  = ($urandom_range(99) < irdy_pct);
        i_redirect    = redir;
        i_redirect_pc = rpc;
        if (arm_redir && i_mem_valid && o_inst_valid && i_inst_ready) begin
            i_redirect    = 1'b1;
            i_redirect_pc = arm_pc;
            arm_redir     = 1'b0;
            arm_hit       = 1'b1;
        end
        #1;
        if (prev_stall && !i_redirect) begin
            check_eq("req_hold", o_mem_req, 1);
            check_eq("addr_hold", o_mem_addr, prev_addr);
        end
        if (o_mem_req) check_eq("addr_align", o_mem_addr[1:0], 0);
        if (in_fault) check_eq("fault_no_req", o_mem_req, 0);
        if (first_valid >= 0 && cyc > first_valid && !o_inst_valid) gaps++;
        if (o_inst_valid && first_valid < 0) first_valid = cyc;

        // Consumer handshake is judged before this cycle's redirect takes effect.
        if (o_inst_valid && i_inst_ready) begin
            cons_cnt++;
            if (exp_fault_next) begin
                check_eq("fault_flag", o_inst_fault, 1);
                check_eq("fault_pc", o_inst_pc, fault_pc);
                check_eq("fault_inst", o_inst, 32'h0);
                exp_fault_next = 1'b0;
                fault_seen++;
            end else if (in_fault) begin
                check_eq("entry_after_fault", 1, 0);
            end else begin
                check_eq("inst_pc", o_inst_pc, exp_pc);
                check_eq("inst_word", o_inst, mem_word(exp_pc));
                check_eq("inst_fault", o_inst_fault, 0);
                exp_pc = exp_pc + 32'd4;
            end
        end

        if (i_mem_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (o_mem_req && i_mem_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            pend_addr.push_back(o_mem_addr);
            pend_due.push_back(cyc + lat);
            req_cnt++;
            if (first_acc < 0) begin
                first_acc      = cyc;
                first_acc_addr = o_mem_addr;
            end
        end

        if (i_redirect) begin
            if (i_redirect_pc[1:0] == 2'b00) begin
                exp_pc         = i_redirect_pc;
                in_fault       = 1'b0;
                exp_fault_next = 1'b0;
            end else begin
                fault_pc       = i_redirect_pc;
                in_fault       = 1'b1;
                exp_fault_next = 1'b1;
            end
        end
        prev_stall = o_mem_req && !i_mem_ready && !i_redirect;
        prev_addr  = o_mem_addr;

        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0);
    endtask

    initial begin
        int c0;
        logic [31:0] rpc;
        bit rd;
        lat_min   = 1;
        lat_max   = 1;
        mrdy_pct  = 100;
        irdy_pct  = 100;
        arm_redir = 1'b0;
        arm_hit   = 1'b0;
        arm_pc    = 32'h0;
        i_rst_n   = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'h0;
        i_inst_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        #1;
        check_eq("rst_mem_req", o_mem_req, 0);
        check_eq("rst_inst_valid", o_inst_valid, 0);
        check_eq("rst_inst_fault", o_inst_fault, 0);

        // Zero-wait memory, always-ready consumer.
        do_reset();
        run(30);
        check_eq("first_latency", first_valid, first_acc + 2);
        check_eq("first_addr", first_acc_addr, RESET_ADDR);
        check_eq("stream_gaps", gaps, 0);
        check_eq("stream_flow", cons_cnt >= 25, 1);

        // Stalled consumer fills the queue, then drains in order.
        do_reset();
        irdy_pct = 0;
        run(10);
        check_eq("full_req_cnt", req_cnt, DEPTH);
        check_eq("full_no_req", o_mem_req, 0);
        check_eq("full_valid", o_inst_valid, 1);
        check_eq("full_head_pc", o_inst_pc, RESET_ADDR);
        irdy_pct = 100;
        run(6);
        check_eq("drain_cnt", cons_cnt >= DEPTH, 1);

        // Redirect with two stale requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        run(3);
        check_eq("inflight_before_redir", pend_addr.size() >= 2, 1);
        step(1'b1, 32'h0000_0100);
        c0 = cons_cnt;
        run(15);
        check_eq("post_redir_flow", cons_cnt - c0 >= 5, 1);

        // Redirect in the same cycle as a response and a consumer handshake.
        do_reset();
        lat_min   = 2;
        lat_max   = 2;
        arm_redir = 1'b1;
        arm_pc    = 32'h0000_0800;
        for (int k = 0; k < 50 && arm_redir; k++) step(1'b0, 32'h0);
        check_eq("redir_hit_found", arm_hit, 1);
        arm_redir = 1'b0;
        c0 = cons_cnt;
        run(20);
        check_eq("hit_redir_flow", cons_cnt - c0 >= 10, 1);

        // Misaligned redirect parks the unit until the next redirect.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        run(5);
        step(1'b1, 32'h0000_0202);
        run(10);
        check_eq("fault_entries", fault_seen, 1);
        step(1'b1, 32'h0000_0300);
        c0 = cons_cnt;
        run(10);
        check_eq("post_fault_flow", cons_cnt - c0 >= 5, 1);

        // Randomized traffic with redirects, faults and pc wrap.
        do_reset();
        lat_min  = 1;
        lat_max  = 4;
        mrdy_pct = 70;
        irdy_pct = 60;
        for (int k = 0; k < 3000; k++) begin
            rd  = ($urandom_range(39) == 0) || (in_fault && $urandom_range(7) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF0;
            if ($urandom_range(3) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
            step(rd, rpc);
        end
        check_eq("random_flow", cons_cnt > 500, 1);

        // Asynchronous reset with a full queue.
        do_reset();
        lat_min  = 1;
        lat_max  = 1;
        mrdy_pct = 100;
        irdy_pct = 0;
        run(10);
        check_eq("pre_rst_valid", o_inst_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", o_inst_valid, 0);
        check_eq("async_rst_req", o_mem_req, 0);
        check_eq("async_rst_fault", o_inst_fault, 0);
        do_reset();
        irdy_pct = 100;
        run(8);
        check_eq("post_rst_addr", first_acc_addr, RESET_ADDR);
        check_eq("post_rst_flow", cons_cnt >= 4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
